div_issue_ctrl: RTL and testbench

//   Sequences one 32-bit divide/modulo op at a time through the shared signed and unsigned divider IPs for the EX stage.

---
 rtl/div_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_div_issue_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the shared signed/unsigned divider IPs.
// Sequences one op at a time, holds the result for EX and drains cancelled ops.
module div_issue_ctrl #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_signed,
  input  logic [W-1:0]   req_dividend,
  input  logic [W-1:0]   req_divisor,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [W-1:0]   resp_quot,
  output logic [W-1:0]   resp_rem,
  output logic           busy,
  output logic           s_tvalid,
  input  logic           s_dvd_tready,
  input  logic           s_dvs_tready,
  output logic           u_tvalid,
  input  logic           u_dvd_tready,
  input  logic           u_dvs_tready,
  output logic [W-1:0]   ip_dividend,
  output logic [W-1:0]   ip_divisor,
  input  logic           s_out_tvalid,
  input  logic [2*W-1:0] s_out_tdata,
  input  logic           u_out_tvalid,
  input  logic [2*W-1:0] u_out_tdata
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, DRAIN} state_t;

  state_t         state;
  logic           sel_signed;
  logic           dvd_done;
  logic           dvs_done;
  logic [W-1:0]   dvd_q;
  logic [W-1:0]   dvs_q;
  logic [W-1:0]   quot_q;
  logic [W-1:0]   rem_q;

  logic           sending;
  logic           dvd_rdy;
  logic           dvs_rdy;
  logic           dvd_nxt;
  logic           dvs_nxt;
  logic           out_v;
  logic [2*W-1:0] out_d;
  logic           accept;

  // A drained op keeps driving whichever channel the IP has not yet taken.
  assign sending = (state == SEND) || ((state == DRAIN) && !(dvd_done && dvs_done));
  assign dvd_rdy = sel_signed ? s_dvd_tready : u_dvd_tready;
  assign dvs_rdy = sel_signed ? s_dvs_tready : u_dvs_tready;
  assign dvd_nxt = dvd_done || (sending && dvd_rdy);
  assign dvs_nxt = dvs_done || (sending && dvs_rdy);
  assign out_v   = sel_signed ? s_out_tvalid : u_out_tvalid;
  assign out_d   = sel_signed ? s_out_tdata : u_out_tdata;
  assign accept  = req_valid && req_ready;

  assign req_ready   = (state == IDLE) && !flush;
  assign resp_valid  = (state == DONE);
  assign busy        = (state != IDLE);
  assign s_tvalid    = sending && sel_signed;
  assign u_tvalid    = sending && !sel_signed;
  assign ip_dividend = dvd_q;
  assign ip_divisor  = dvs_q;
  assign resp_quot   = quot_q;
  assign resp_rem    = rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_signed <= 1'b0;
      dvd_done   <= 1'b0;
      dvs_done   <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_q      <= req_dividend;
            dvs_q      <= req_divisor;
            sel_signed <= req_signed;
            dvd_done   <= 1'b0;
            dvs_done   <= 1'b0;
            state      <= SEND;
          end
        end
        SEND: begin
          dvd_done <= dvd_nxt;
          dvs_done <= dvs_nxt;
          // Any channel taken by the IP (even this cycle) must be completed.
          if (flush)                 state <= (dvd_nxt || dvs_nxt) ? DRAIN : IDLE;
          else if (dvd_nxt && dvs_nxt) state <= WAIT;
        end
        WAIT: begin
          // A result arriving with the flush is simply dropped.
          if (flush) state <= out_v ? IDLE : DRAIN;
          else if (out_v) begin
            quot_q <= out_d[2*W-1:W];
            rem_q  <= out_d[W-1:0];
            state  <= DONE;
          end
        end
        DONE: begin
          if (flush || resp_ready) state <= IDLE;
        end
        DRAIN: begin
          dvd_done <= dvd_nxt;
          dvs_done <= dvs_nxt;
          if (out_v) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with behavioural signed/unsigned divider IP models.
module tb_div_issue_ctrl;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           req_valid;
  logic           req_ready;
  logic           req_signed;
  logic [W-1:0]   req_dividend;
  logic [W-1:0]   req_divisor;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_quot;
  logic [W-1:0]   resp_rem;
  logic           busy;
  logic           s_tvalid;
  logic           s_dvd_tready;
  logic           s_dvs_tready;
  logic           u_tvalid;
  logic           u_dvd_tready;
  logic           u_dvs_tready;
  logic [W-1:0]   ip_dividend;
  logic [W-1:0]   ip_divisor;
  logic           s_out_tvalid;
  logic [2*W-1:0] s_out_tdata;
  logic           u_out_tvalid;
  logic [2*W-1:0] u_out_tdata;

  int checks = 0;
  int failures = 0;
  int ip_lat = 0;

  div_issue_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quot(resp_quot), .resp_rem(resp_rem), .busy(busy),
    .s_tvalid(s_tvalid), .s_dvd_tready(s_dvd_tready), .s_dvs_tready(s_dvs_tready),
    .u_tvalid(u_tvalid), .u_dvd_tready(u_dvd_tready), .u_dvs_tready(u_dvs_tready),
    .ip_dividend(ip_dividend), .ip_divisor(ip_divisor),
    .s_out_tvalid(s_out_tvalid), .s_out_tdata(s_out_tdata),
    .u_out_tvalid(u_out_tvalid), .u_out_tdata(u_out_tdata)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] sdiv(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, q, r;
    sa = a; sb = b;
    q = sa / sb;
    r = sa % sb;
    return {q, r};
  endfunction

  function automatic logic [2*W-1:0] udiv(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a / b, a % b};
  endfunction

  // Divider IP models: each channel taken once, result ip_lat+1 cycles after both arrive.
  logic s_hd, s_hv, u_hd, u_hv;
  logic [W-1:0] s_a, s_b, u_a, u_b;
  int s_cnt, u_cnt;

  always @(posedge clk) begin
    if (rst) begin
      s_hd <= 1'b0; s_hv <= 1'b0; s_cnt <= 0; s_out_tvalid <= 1'b0; s_out_tdata <= '0;
      s_a <= '0; s_b <= '0;
    end else begin
      s_out_tvalid <= 1'b0;
      if (s_hd && s_hv) begin
        if (s_cnt >= ip_lat) begin
          s_out_tvalid <= 1'b1; s_out_tdata <= sdiv(s_a, s_b);
          s_hd <= 1'b0; s_hv <= 1'b0; s_cnt <= 0;
        end else s_cnt <= s_cnt + 1;
      end else begin
        if (s_tvalid && s_dvd_tready && !s_hd) begin s_a <= ip_dividend; s_hd <= 1'b1; end
        if (s_tvalid && s_dvs_tready && !s_hv) begin s_b <= ip_divisor; s_hv <= 1'b1; end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      u_hd <= 1'b0; u_hv <= 1'b0; u_cnt <= 0; u_out_tvalid <= 1'b0; u_out_tdata <= '0;
      u_a <= '0; u_b <= '0;
    end else begin
      u_out_tvalid <= 1'b0;
      if (u_hd && u_hv) begin
        if (u_cnt >= ip_lat) begin
          u_out_tvalid <= 1'b1; u_out_tdata <= udiv(u_a, u_b);
          u_hd <= 1'b0; u_hv <= 1'b0; u_cnt <= 0;
        end else u_cnt <= u_cnt + 1;
      end else begin
        if (u_tvalid && u_dvd_tready && !u_hd) begin u_a <= ip_dividend; u_hd <= 1'b1; end
        if (u_tvalid && u_dvs_tready && !u_hv) begin u_b <= ip_divisor; u_hv <= 1'b1; end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_treadys(input logic v);
    s_dvd_tready = v; s_dvs_tready = v; u_dvd_tready = v; u_dvs_tready = v;
  endtask

  // Wait for resp_valid within a bound, counting unselected-IP tvalid cycles.
  task automatic wait_resp(input string tag, input logic sgn, output int unsel);
    int n = 0;
    unsel = 0;
    while (!resp_valid && n < 40) begin
      if (sgn ? u_tvalid : s_tvalid) unsel++;
      step();
      n++;
    end
    check({tag, "_resp_to"}, 64'(resp_valid), 64'd1);
  endtask

  // Wait for the controller to return idle, checking nothing leaks onto resp.
  task automatic wait_idle(input string tag);
    int n = 0;
    int leak = 0;
    while (busy && n < 40) begin
      if (resp_valid || req_ready) leak++;
      step();
      n++;
    end
    check({tag, "_idle_to"}, 64'(busy), 64'd0);
    check({tag, "_leak"}, 64'(leak), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input int hold);
    int unsel;
    set_treadys(1'b1);
    req_valid = 1'b1; req_signed = sgn; req_dividend = a; req_divisor = b;
    step();
    req_valid = 1'b0;
    check({tag, "_tv1"}, 64'(sgn ? s_tvalid : u_tvalid), 64'd1);
    step();
    check({tag, "_tv2"}, 64'(sgn ? s_tvalid : u_tvalid), 64'd0);
    wait_resp(tag, sgn, unsel);
    check({tag, "_unsel"}, 64'(unsel), 64'd0);
    check({tag, "_quot"}, 64'(resp_quot), 64'(eq));
    check({tag, "_rem"}, 64'(resp_rem), 64'(er));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_v"}, 64'(resp_valid), 64'd1);
      check({tag, "_hold_d"}, {resp_quot, resp_rem}, {eq, er});
      check({tag, "_hold_rr"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_drop"}, 64'(resp_valid), 64'd0);
    check({tag, "_idle"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int unsel;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_signed = 1'b0;
    req_dividend = '0; req_divisor = '0; resp_ready = 1'b0;
    set_treadys(1'b0);
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp", 64'(resp_valid), 64'd0);
    check("rst_tv", {62'd0, s_tvalid, u_tvalid}, 64'd0);
    check("rst_data", {resp_quot, resp_rem}, 64'd0);
    rst = 1'b0;
    step();
    check("rst_rr", 64'(req_ready), 64'd1);

    run_op("s7d2", 1'b1, 32'd7, 32'd2, 32'd3, 32'd1, 0);
    run_op("sneg", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run_op("umax", 1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 5);

    // Channels complete in different cycles
    set_treadys(1'b0);
    u_dvd_tready = 1'b1;
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd100; req_divisor = 32'd7;
    step();
    req_valid = 1'b0;
    check("split_c1", 64'(u_tvalid), 64'd1);
    step();
    u_dvd_tready = 1'b0;
    check("split_c2", 64'(u_tvalid), 64'd1);
    step();
    check("split_c3", 64'(u_tvalid), 64'd1);
    step();
    u_dvs_tready = 1'b1;
    check("split_c4", 64'(u_tvalid), 64'd1);
    step();
    u_dvs_tready = 1'b0;
    check("split_c5", {61'd0, u_tvalid, busy, req_ready}, 64'b010);
    wait_resp("split", 1'b0, unsel);
    check("split_unsel", 64'(unsel), 64'd0);
    check("split_res", {resp_quot, resp_rem}, {32'd14, 32'd2});
    resp_ready = 1'b1; step(); resp_ready = 1'b0;

    // Flush in WAIT: result discarded, next op blocked until the IP answers
    ip_lat = 6;
    set_treadys(1'b1);
    req_valid = 1'b1; req_signed = 1'b1; req_dividend = 32'd20; req_divisor = 32'd3;
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    ip_lat = 0;
    req_valid = 1'b1; req_dividend = 32'd9; req_divisor = 32'd3;
    check("wflush_drain", {62'd0, busy, req_ready}, 64'b10);
    wait_idle("wflush");
    step();
    req_valid = 1'b0;
    check("wflush_next_tv", 64'(s_tvalid), 64'd1);
    wait_resp("nine", 1'b1, unsel);
    check("nine_res", {resp_quot, resp_rem}, {32'd3, 32'd0});
    resp_ready = 1'b1; step(); resp_ready = 1'b0;

    // Flush in SEND after only the dividend was taken
    set_treadys(1'b0);
    s_dvd_tready = 1'b1;
    req_valid = 1'b1; req_signed = 1'b1; req_dividend = 32'd50; req_divisor = 32'd5;
    step();
    req_valid = 1'b0;
    step();
    s_dvd_tready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sflush_drain", {61'd0, s_tvalid, busy, req_ready}, 64'b110);
    step();
    s_dvs_tready = 1'b1;
    check("sflush_tv", 64'(s_tvalid), 64'd1);
    step();
    s_dvs_tready = 1'b0;
    check("sflush_tv_off", 64'(s_tvalid), 64'd0);
    wait_idle("sflush");
    check("sflush_ip_clean", {62'd0, s_hd, s_hv}, 64'd0);

    // Flush in SEND before any channel: straight back to idle
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd8; req_divisor = 32'd2;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("s0flush", {62'd0, u_tvalid, busy}, 64'd0);

    // Flush in the accept cycle masks req_ready
    req_valid = 1'b1; flush = 1'b1;
    #1;
    check("aflush_rr", 64'(req_ready), 64'd0);
    step();
    req_valid = 1'b0; flush = 1'b0;
    check("aflush_busy", 64'(busy), 64'd0);

    // Flush in DONE drops resp_valid
    set_treadys(1'b1);
    req_valid = 1'b1; req_signed = 1'b1; req_dividend = 32'd7; req_divisor = 32'd2;
    step();
    req_valid = 1'b0;
    wait_resp("dflush", 1'b1, unsel);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("dflush_drop", {62'd0, resp_valid, busy}, 64'd0);

    // Reset mid-op
    req_valid = 1'b1; req_dividend = 32'd6; req_divisor = 32'd3;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst", {61'd0, busy, s_tvalid, s_out_tvalid}, 64'd0);
    run_op("post_rst", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
